unified_mem_arbiter: RTL

- Shares one single-ported unified instruction/data memory between instruction fetch (IF) and data load/store (D).
- Sequences each access as issue, then a fixed-latency wait, then a completion pulse.
- Drives the pipeline stall line so the CPU holds while its request is pending.
- Sits between the fetch/datapath and the memory macro. It consumes the load/store enables that the control unit produces.

---
 rtl/unified_mem_arbiter_if.sv | 55 +++++
 rtl/unified_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch/datapath, the unified memory arbiter and the memory macro.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    // Fetch side
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_valid_o;

    // Data side
    logic              d_rd_i;
    logic              d_wr_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [BE_W-1:0]   d_be_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_done_o;

    // Pipeline
    logic              stall_o;

    // Memory macro side
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter view
    modport slave (
        input  if_req_i, if_addr_i,
        input  d_rd_i, d_wr_i, d_addr_i, d_wdata_i, d_be_i,
        input  mem_rdata_i,
        output if_rdata_o, if_valid_o,
        output d_rdata_o, d_done_o,
        output stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    // Environment view (CPU requesters plus memory macro)
    modport master (
        output if_req_i, if_addr_i,
        output d_rd_i, d_wr_i, d_addr_i, d_wdata_i, d_be_i,
        output mem_rdata_i,
        input  if_rdata_o, if_valid_o,
        input  d_rdata_o, d_done_o,
        input  stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch
// and data load/store. Each access runs IDLE -> ISSUE -> WAIT(MEM_LAT) -> DONE.
// Optional macro ARB_PERF_CNT_EN adds per-requester wait-cycle counters.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    unified_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_if_wait_o,
    output logic [31:0]          perf_d_wait_o
`endif
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_d_q, last_d_d;   // 1: data side won the most recent grant
    logic              gnt_d_q, gnt_d_d;     // access in flight belongs to data side
    logic              gnt_wr_q, gnt_wr_d;   // access in flight is a store

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;

    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_done_q, d_done_d;

    logic              d_req_c;

    assign d_req_c = bus.d_rd_i | bus.d_wr_i;

    // Next-state, arbitration, issue payload and read-data capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        gnt_d_d     = gnt_d_q;
        gnt_wr_d    = gnt_wr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_be_d    = '0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Data wins when alone, or under contention when fetch won last
                if (d_req_c && (!bus.if_req_i || !last_d_q)) begin
                    state_d    = ST_ISSUE;
                    last_d_d   = 1'b1;
                    gnt_d_d    = 1'b1;
                    gnt_wr_d   = bus.d_wr_i;
                    mem_en_d   = 1'b1;
                    mem_we_d   = bus.d_wr_i;
                    mem_addr_d = bus.d_addr_i;
                    if (bus.d_wr_i) begin
                        mem_wdata_d = bus.d_wdata_i;
                        mem_be_d    = bus.d_be_i;
                    end else begin
                        mem_be_d    = '1;
                    end
                end else if (bus.if_req_i) begin
                    state_d    = ST_ISSUE;
                    last_d_d   = 1'b0;
                    gnt_d_d    = 1'b0;
                    gnt_wr_d   = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.if_addr_i;
                    mem_be_d   = '1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MEM_LAT);
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (gnt_d_q) begin
                        d_done_d = 1'b1;
                        if (!gnt_wr_q) begin
                            d_rdata_d = bus.mem_rdata_i;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_d_q    <= 1'b0;
            gnt_d_q     <= 1'b0;
            gnt_wr_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_d_q    <= last_d_d;
            gnt_d_q     <= gnt_d_d;
            gnt_wr_q    <= gnt_wr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_done_q    <= d_done_d;
        end
    end

    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_be_o    = mem_be_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_valid_o  = if_valid_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.d_done_o    = d_done_q;

    // Hold the pipeline while either requester is pending and not completing
    assign bus.stall_o = (d_req_c & ~d_done_q) | (bus.if_req_i & ~if_valid_q);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q;
    logic [31:0] perf_d_q;
    logic        if_served_c;
    logic        d_served_c;

    assign if_served_c = (state_q != ST_IDLE) && !gnt_d_q;
    assign d_served_c  = (state_q != ST_IDLE) &&  gnt_d_q;

    // Saturating counts of cycles each requester spends waiting
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
        end else begin
            if (bus.if_req_i && !if_served_c && (perf_if_q != 32'hFFFF_FFFF)) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (d_req_c && !d_served_c && (perf_d_q != 32'hFFFF_FFFF)) begin
                perf_d_q <= perf_d_q + 32'd1;
            end
        end
    end

    assign perf_if_wait_o = perf_if_q;
    assign perf_d_wait_o  = perf_d_q;
`endif

endmodule
